// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned
// multiply (shift-add) and restoring divide into a hi/lo pair, all outputs registered.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       gin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] hi,
    output logic             zout,
    output logic             nout,
    output logic             ovf,
    output logic             dz,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             dzf_q, dzf_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zout_q, zout_d;
    logic             nout_q, nout_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] add_r, sub_r, r1;
    logic             ov1;
    logic [WIDTH:0]   msum, shifted, trial;
    logic [WIDTH-1:0] lo_step;
    logic [WIDTH:0]   acc_step;
    logic             accept, is_multi;

    assign add_r = a + b;
    assign sub_r = a - b;

    always_comb begin
        r1  = '0;
        ov1 = 1'b0;
        case (gin)
            4'b0000: r1 = a & b;
            4'b0001: r1 = a | b;
            4'b0010: begin
                r1  = add_r;
                ov1 = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                r1  = sub_r;
                ov1 = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: r1 = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: r1 = b >> shamt;
            4'b0100: r1 = b << shamt;
            4'b0101: r1 = $signed(b) >>> shamt;
            default: r1 = '0;
        endcase
    end

    // One iteration: multiply consumes the multiplier LSB from lo and shifts the
    // product right; divide shifts the dividend MSB into the partial remainder.
    always_comb begin
        msum    = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opb_q} : '0);
        shifted = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, opb_q};
        if (is_div_q) begin
            if (trial[WIDTH]) begin
                acc_step = shifted;
                lo_step  = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_step = trial;
                lo_step  = {lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step = {1'b0, msum[WIDTH:1]};
            lo_step  = {msum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Handshake: start is accepted on any edge where busy=0; done pulses for the
    // cycle after completion and results hold until the next op completes.
    assign accept   = start && (state_q != S_RUN);
    assign is_multi = (gin == 4'b1000) || (gin == 4'b1001);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        dzf_d    = dzf_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        sum_d    = sum_q;
        hi_d     = hi_q;
        zout_d   = zout_q;
        nout_d   = nout_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (is_multi) begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = gin[0];
                        dzf_d    = gin[0] && (b == '0);
                        lo_d     = a;
                        acc_d    = '0;
                        opb_d    = b;
                    end else begin
                        state_d = S_DONE;
                        sum_d   = r1;
                        hi_d    = '0;
                        zout_d  = ~|r1;
                        nout_d  = r1[WIDTH-1];
                        ovf_d   = ov1;
                        dz_d    = 1'b0;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                lo_d  = lo_step;
                acc_d = acc_step;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    sum_d   = lo_step;
                    hi_d    = acc_step[WIDTH-1:0];
                    zout_d  = ~|lo_step;
                    nout_d  = lo_step[WIDTH-1];
                    ovf_d   = 1'b0;
                    dz_d    = dzf_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dzf_q    <= 1'b0;
            lo_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            sum_q    <= '0;
            hi_q     <= '0;
            zout_q   <= 1'b0;
            nout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            dzf_q    <= dzf_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            sum_q    <= sum_d;
            hi_q     <= hi_d;
            zout_q   <= zout_d;
            nout_q   <= nout_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign hi        = hi_q;
    assign zout      = zout_q;
    assign nout      = nout_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32, SHW=6 so shift amounts past the word width are reachable):
// directed and random ops checked against a plain-arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;
    localparam int S = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    gin = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [S-1:0]  shamt = '0;
    logic          busy, done, zout, nout, ovf, dz;
    logic [W-1:0]  sum, hi;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(W), .SHW(S)) dut (
        .clk(clk), .reset(reset), .start(start), .gin(gin), .a(a), .b(b),
        .shamt(shamt), .busy(busy), .done(done), .sum(sum), .hi(hi),
        .zout(zout), .nout(nout), .ovf(ovf), .dz(dz), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: results straight from the opcode definitions using 64-bit arithmetic.
    task automatic model(input logic [3:0] g, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic [S-1:0] sh, output logic [W-1:0] s, output logic [W-1:0] h,
                         output logic o, output logic d, output int lat);
        longint      sa, sb, sr;
        logic [63:0] w;
        sa = $signed(oa);
        sb = $signed(ob);
        s = '0; h = '0; o = 1'b0; d = 1'b0; lat = 1;
        case (g)
            4'b0000: s = oa & ob;
            4'b0001: s = oa | ob;
            4'b0010: begin
                sr = sa + sb; w = sr; s = w[31:0];
                o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0110: begin
                sr = sa - sb; w = sr; s = w[31:0];
                o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0111: s = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: s = (sh >= W) ? '0 : ob >> sh;
            4'b0100: begin w = {32'b0, ob} << sh; s = w[31:0]; end
            4'b0101: begin sr = sb >>> sh; w = sr; s = w[31:0]; end
            4'b1000: begin w = {32'b0, oa} * {32'b0, ob}; s = w[31:0]; h = w[63:32]; lat = W + 1; end
            4'b1001: begin
                lat = W + 1;
                if (ob == 0) begin s = '1; h = oa; d = 1'b1; end
                else begin s = oa / ob; h = oa % ob; end
            end
            default: ;
        endcase
    endtask

    // Runs one op. pre=1: caller already drove start at this negedge.
    // chain=1: at the done cycle, drive the next op (g2/a2/b2) with start held high.
    task automatic run_op(input logic [3:0] g, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic [S-1:0] sh, input bit pre, input bit poke, input bit chain,
                          input logic [3:0] g2, input logic [W-1:0] a2, input logic [W-1:0] b2);
        logic [W-1:0] es, eh;
        logic         eo, ed;
        int           elat, lat, busy_cnt;
        bit           seen;
        model(g, oa, ob, sh, es, eh, eo, ed, elat);
        if (!pre) begin
            @(negedge clk);
            gin = g; a = oa; b = ob; shamt = sh; start = 1'b1;
        end
        @(posedge clk);
        lat = 0; busy_cnt = 0; seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0; a = $urandom; b = $urandom; shamt = S'($urandom); gin = 4'($urandom);
            end
            if (poke && lat == 10) begin start = 1'b1; gin = 4'b0010; end
            if (poke && lat == 11) start = 1'b0;
            if (done) seen = 1;
            else if (busy) busy_cnt++;
        end
        check("latency", 64'(lat), 64'(elat));
        check("busy_cycles", 64'(busy_cnt), 64'(elat - 1));
        check("sum", 64'(sum), 64'(es));
        check("hi", 64'(hi), 64'(eh));
        check("zout", 64'(zout), 64'(es == 0));
        check("nout", 64'(nout), 64'(es[W-1]));
        check("ovf", 64'(ovf), 64'(eo));
        check("dz", 64'(dz), 64'(ed));
        if (chain) begin
            gin = g2; a = a2; b = b2; shamt = '0; start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_pulse", 64'(done), 64'(0));
            check("sum_hold", 64'(sum), 64'(es));
        end
    endtask

    initial begin
        logic [3:0]   rg;
        logic [W-1:0] ra, rb;
        logic [S-1:0] rs;

        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_flags", 64'({zout, nout, ovf, dz}), 64'(0));
        reset = 1'b0;

        run_op(4'b0010, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b0110, 32'd5, 32'd5, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b0111, 32'h80000000, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b0101, 32'h0, 32'hF0000000, 6'd4, 0, 0, 0, 0, 0, 0);
        run_op(4'b0101, 32'h0, 32'h80000001, 6'd40, 0, 0, 0, 0, 0, 0);
        run_op(4'b0011, 32'h0, 32'hFFFFFFFF, 6'd32, 0, 0, 0, 0, 0, 0);
        run_op(4'b0100, 32'h0, 32'hFFFFFFFF, 6'd63, 0, 0, 0, 0, 0, 0);
        run_op(4'b0100, 32'h0, 32'h0000F00F, 6'd8, 0, 0, 0, 0, 0, 0);
        run_op(4'b0010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b0110, 32'h80000000, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b1000, 32'hFFFFFFFF, 32'h2, 0, 0, 1, 0, 0, 0, 0);
        run_op(4'b1001, 32'd100, 32'd7, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b1001, 32'd9, 32'd0, 0, 0, 0, 0, 0, 0, 0);
        run_op(4'b1000, 32'hDEADBEEF, 32'h1234567, 0, 0, 0, 1, 4'b0010, 32'd2, 32'd3);
        run_op(4'b0010, 32'd2, 32'd3, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rg = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            rs = S'($urandom_range(0, 63));
            run_op(rg, ra, rb, rs, 0, 0, 0, 0, 0, 0);
        end

        run_op(4'b1000, 32'hFFFF, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        gin = 4'b1001; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_done", 64'(done), 64'(0));
        run_op(4'b0010, 32'd40, 32'd2, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
